// File: rtl/gpu_pkg.sv
// Constants and types shared by the GPU cores and the shared-memory responder.
package gpu_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Round-robin successor of index v among n slots.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  int            sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    sum           = 0;
    idx           = '0;
    // Walk offsets from farthest to nearest so the requester closest to ptr_i wins last.
    for (int off = N - 1; off >= 0; off--) begin
      sum = int'(ptr_i) + off;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IW'(sum);
      if (req_i[idx]) begin
        grant_idx_o   = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared-memory responder: round-robin arbitration over core requests, one access per 3 cycles.
module shared_mem_responder #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = gpu_pkg::ADDR_W,
  parameter int DATA_W  = gpu_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        mem_req,
  input  logic [N_CORES-1:0]        mem_we,
  input  logic [N_CORES*ADDR_W-1:0] mem_addr,
  input  logic [N_CORES*DATA_W-1:0] mem_wdata,
  output logic [N_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  import gpu_pkg::*;

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  // Handshake: a core raises mem_req[k] (with we/addr/wdata stable) and holds it until the
  // edge at which it samples val_data[k]=1; requests are only looked at while IDLE, so the
  // still-high req of the core being answered in RESP is never served twice.
  state_e              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_CORES-1:0]  val_q;

  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  rr_arbiter #(
    .N  (N_CORES),
    .IW (IW)
  ) u_arb (
    .req_i         (mem_req),
    .ptr_i         (rr_ptr_q),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      val_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q   <= arb_idx;
            we_q    <= mem_we[arb_idx];
            addr_q  <= mem_addr[arb_idx*ADDR_W +: ADDR_W];
            wdata_q <= mem_wdata[arb_idx*DATA_W +: DATA_W];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= mem[addr_q];
          end
          val_q    <= N_CORES'(1) << gnt_q;
          rr_ptr_q <= IW'(wrap_inc(int'(gnt_q), N_CORES));
          state_q  <= RESP;
        end
        RESP: begin
          val_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          val_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; a reset during ACCESS drops state_q to IDLE so the write never lands.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign val_data  = val_q;
  assign mem_rdata = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
